// File: rtl/vm_coin_feeder_if.sv
// Coin interface bundle between the customer-side feeder and the host/machine.
// The master side is the feeder itself; the slave side is the host plus vending machine.
interface vm_coin_feeder_if #(
  parameter int PRICE_W = 4
);
  logic               start;
  logic [PRICE_W-1:0] price_q;
  logic               pay_dollar;
  logic               dispense;
  logic               change;
  logic               quarter;
  logic               dollar;
  logic               busy;
  logic               done;
  logic               err;
  logic [PRICE_W-1:0] coins_sent;
  logic               change_seen;

  modport master (
    input  start, price_q, pay_dollar, dispense, change,
    output quarter, dollar, busy, done, err, coins_sent, change_seen
  );

  modport slave (
    output start, price_q, pay_dollar, dispense, change,
    input  quarter, dollar, busy, done, err, coins_sent, change_seen
  );
endinterface

// File: rtl/vm_coin_feeder.sv
// Customer-side coin initiator: issues quarter or dollar pulses for a purchase,
// then waits for the machine to dispense and reports done or err.
module vm_coin_feeder #(
  parameter int PRICE_W = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 8
) (
  input logic               clk,
  input logic               rst,
  vm_coin_feeder_if.master  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAPW = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  logic [1:0]         state;
  logic               mode_dollar;
  logic [PRICE_W-1:0] price;
  logic [PRICE_W-1:0] coins;
  logic [TW-1:0]      timer;
  logic [GW-1:0]      gapcnt;
  logic               done_r;
  logic               err_r;
  logic               change_r;
  logic               last_coin;

  // A dollar purchase is always a single pulse; a quarter purchase ends on the price-th coin.
  assign last_coin = mode_dollar || (PRICE_W'(coins + 1'b1) == price);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_dollar <= 1'b0;
      price       <= '0;
      coins       <= '0;
      timer       <= '0;
      gapcnt      <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      change_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (state != IDLE && bus.change) begin
        change_r <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.price_q == '0) begin
              err_r <= 1'b1;
            end else begin
              price       <= bus.price_q;
              mode_dollar <= bus.pay_dollar && (32'(bus.price_q) <= 32'd4);
              coins       <= '0;
              change_r    <= 1'b0;
              state       <= SEND;
            end
          end
        end
        SEND: begin
          coins <= coins + 1'b1;
          if (bus.dispense) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end else if (last_coin) begin
            timer <= '0;
            state <= WAIT;
          end else if (GAP == 0) begin
            state <= SEND;
          end else begin
            gapcnt <= '0;
            state  <= GAPW;
          end
        end
        GAPW: begin
          if (bus.dispense) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end else if (gapcnt == GW'(GAP - 1)) begin
            state <= SEND;
          end else begin
            gapcnt <= gapcnt + 1'b1;
          end
        end
        WAIT: begin
          // Dispense on the final timeout cycle still counts as success.
          if (bus.dispense) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err_r <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quarter     = (state == SEND) && !mode_dollar;
  assign bus.dollar      = (state == SEND) && mode_dollar;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.err         = err_r;
  assign bus.coins_sent  = coins;
  assign bus.change_seen = change_r;

endmodule

// File: tb/tb_vm_coin_feeder.sv
// Bench for vm_coin_feeder: two instances (GAP=1 and GAP=0) share stimulus and are
// compared every cycle against a purchase-level schedule model.
module tb_vm_coin_feeder;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  vm_coin_feeder_if #(.PRICE_W(4)) busA ();
  vm_coin_feeder_if #(.PRICE_W(4)) busB ();

  vm_coin_feeder #(.PRICE_W(4), .GAP(1), .TIMEOUT(TO)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  vm_coin_feeder #(.PRICE_W(4), .GAP(0), .TIMEOUT(TO)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Model: a purchase is a coin schedule; coin i lands at cycle i*period after start.
  int period [2] = '{2, 1};
  bit mAct   [2];
  int mT     [2];
  int mN     [2];
  bit mDol   [2];
  int mCoins [2];
  bit mChg   [2];
  bit mDone  [2];
  bit mErr   [2];

  function automatic int minOf(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [10:0] expVec(input int k);
    bit q = 1'b0;
    bit d = 1'b0;
    int cs = mCoins[k];
    if (mAct[k]) begin
      bit coinNow = (mT[k] % period[k] == 0) && (mT[k] / period[k] < mN[k]);
      q  = coinNow && !mDol[k];
      d  = coinNow && mDol[k];
      cs = minOf(mN[k], (mT[k] + period[k] - 1) / period[k]);
    end
    return {q, d, mAct[k], mDone[k], mErr[k], 4'(cs), mChg[k]};
  endfunction

  function automatic logic [10:0] dutVec(input int k);
    if (k == 0)
      return {busA.quarter, busA.dollar, busA.busy, busA.done, busA.err,
              busA.coins_sent, busA.change_seen};
    return {busB.quarter, busB.dollar, busB.busy, busB.done, busB.err,
            busB.coins_sent, busB.change_seen};
  endfunction

  task automatic stepModel(input int k, input bit s, input int pr, input bit pd,
                           input bit dsp, input bit chg, input bit r);
    if (r) begin
      mAct[k] = 0; mT[k] = 0; mCoins[k] = 0; mChg[k] = 0; mDone[k] = 0; mErr[k] = 0;
      return;
    end
    mDone[k] = 0;
    mErr[k]  = 0;
    if (!mAct[k]) begin
      if (s) begin
        if (pr == 0) begin
          mErr[k] = 1;
        end else begin
          mAct[k]   = 1;
          mT[k]     = 0;
          mDol[k]   = pd && (pr <= 4);
          mN[k]     = mDol[k] ? 1 : pr;
          mCoins[k] = 0;
          mChg[k]   = 0;
        end
      end
    end else begin
      if (chg) mChg[k] = 1;
      if (dsp) begin
        mDone[k]  = 1;
        mCoins[k] = minOf(mN[k], mT[k] / period[k] + 1);
        mAct[k]   = 0;
      end else if (mT[k] == (mN[k] - 1) * period[k] + TO) begin
        mErr[k]   = 1;
        mCoins[k] = mN[k];
        mAct[k]   = 0;
      end else begin
        mT[k]++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, advance the model across the edge, check at the next negedge.
  task automatic applyStimulus(input bit s, input int pr, input bit pd,
                               input bit dsp, input bit chg, input bit r);
    busA.start = s;  busA.price_q = 4'(pr); busA.pay_dollar = pd;
    busA.dispense = dsp; busA.change = chg;
    busB.start = s;  busB.price_q = 4'(pr); busB.pay_dollar = pd;
    busB.dispense = dsp; busB.change = chg;
    rst = r;
    stepModel(0, s, pr, pd, dsp, chg, r);
    stepModel(1, s, pr, pd, dsp, chg, r);
    @(negedge clk);
    cyc++;
    checkOutput($sformatf("gap1 c%0d", cyc), 32'(dutVec(0)), 32'(expVec(0)));
    checkOutput($sformatf("gap0 c%0d", cyc), 32'(dutVec(1)), 32'(expVec(1)));
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Two quarters, dispense alongside the second GAP=1 quarter.
    applyStimulus(1, 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("t1_done", 32'(busA.done), 32'd1);
    checkOutput("t1_coins", 32'(busA.coins_sent), 32'd2);
    checkOutput("t1_chg", 32'(busA.change_seen), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Single dollar with dispense and change together.
    applyStimulus(1, 4, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("t2_done", 32'(busA.done), 32'd1);
    checkOutput("t2_coins", 32'(busA.coins_sent), 32'd1);
    checkOutput("t2_chg", 32'(busA.change_seen), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // No dispense: timeout after the third quarter.
    applyStimulus(1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t3_coins", 32'(busA.coins_sent), 32'd3);

    // Zero price.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t4_err", 32'(busA.err), 32'd1);
    checkOutput("t4_busy", 32'(busA.busy), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset between the first and second quarter, then a fresh purchase.
    applyStimulus(1, 3, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t5_busy", 32'(busA.busy), 32'd0);
    checkOutput("t5_coins", 32'(busA.coins_sent), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Start re-asserted while busy is ignored.
    applyStimulus(1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t6_coins0", 32'(busB.coins_sent), 32'd5);
    checkOutput("t6_coins1", 32'(busA.coins_sent), 32'd5);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 5) == 0, int'($urandom_range(0, 15)),
                    bit'($urandom_range(0, 1)), $urandom_range(0, 11) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
